// File: rtl/ad100_mem_loader_if.sv
// Byte-stream receive and RAM write-port signals shared by the ad100 loader and its host.
// master = byte source / RAM side, slave = loader side.
interface ad100_mem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ad100_mem_loader.sv
// ad100 RAM loader: framed byte stream (SYNC, N lo, N hi, 4*N data bytes) -> little-endian word writes.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module ad100_mem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reload,
  ad100_mem_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR} state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = CHK;
`else
  localparam state_t LAST_ST = DONE;
`endif
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic              rx_ready_q, mem_we_q, cpu_hold_q, load_done_q, load_err_q;
  logic [ADDR_W-1:0] mem_addr_q, word_idx_q;
  logic [31:0]       mem_wdata_q;
  logic [23:0]       wbuf_q;
  logic [1:0]        byte_q;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       rem_q;
  logic [15:0]       count;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  assign accept = bus.rx_valid & rx_ready_q;
  assign count  = {bus.rx_data, cnt_lo_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept && bus.rx_data == SYNC) state_d = CNT_LO;
      CNT_LO: if (accept) state_d = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if (count == 16'd0)                    state_d = LAST_ST;
          else if ({1'b0, count} > CAPACITY)     state_d = ERR;
          else                                   state_d = DATA;
        end
      end
      DATA:   if (accept && byte_q == 2'd3 && rem_q == 16'd1) state_d = LAST_ST;
`ifdef LOADER_CHECKSUM_EN
      CHK:    if (accept) state_d = (bus.rx_data == chk_q) ? DONE : ERR;
`endif
      DONE:   if (reload) state_d = IDLE;
      ERR:    if (reload) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the same edge as the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      word_idx_q  <= '0;
      wbuf_q      <= '0;
      byte_q      <= '0;
      cnt_lo_q    <= '0;
      rem_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= (state_d != DONE) && (state_d != ERR);
      cpu_hold_q  <= (state_d != DONE);
      load_done_q <= (state_d == DONE);
      load_err_q  <= (state_d == ERR);
      mem_we_q    <= 1'b0;
      if (accept) begin
        case (state_q)
          CNT_LO: cnt_lo_q <= bus.rx_data;
          CNT_HI: begin
            rem_q      <= count;
            word_idx_q <= '0;
            byte_q     <= '0;
          end
          DATA: begin
            byte_q <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx_q;
              mem_wdata_q <= {bus.rx_data, wbuf_q};
              rem_q       <= rem_q - 16'd1;
              if (rem_q != 16'd1) word_idx_q <= word_idx_q + ADDR_W'(1);
            end else begin
              wbuf_q <= {bus.rx_data, wbuf_q[23:8]};
            end
          end
          default: ;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (state_q == IDLE)
          chk_q <= '0;
        else if (state_q == CNT_LO || state_q == CNT_HI || state_q == DATA)
          chk_q <= chk_q ^ bus.rx_data;
`endif
      end
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;

endmodule
